// File: rtl/square_root_pkg.sv
// square_root_pkg: shared state encoding and sizing helper for the iterative square root.
package square_root_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) ;
        return r;
    endfunction
endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one digit-by-digit square root iteration consuming the next radicand bit pair.
module sqrt_step #(parameter int RW = 8) (
    input  logic [RW+1:0] rem_acc,
    input  logic [RW-1:0] root_acc,
    input  logic [1:0]    pair,
    output logic [RW+1:0] rem_nxt,
    output logic [RW-1:0] root_nxt
);
    logic [RW+3:0] trial;
    logic          neg;
    assign trial = {rem_acc, pair} - {2'b00, root_acc, 2'b01};
    // a non-negative trial always stays below 2^(RW+2), so either top bit marks a borrow
    assign neg = |trial[RW+3:RW+2];
    assign rem_nxt = neg ? {rem_acc[RW-1:0], pair} : trial[RW+1:0];
    assign root_nxt = {root_acc[RW-2:0], ~neg};
endmodule

// File: rtl/square_root_seq.sv
// square_root_seq: iterative integer square root, one root bit per cycle,
// with floor/round-to-nearest modes and valid/ready handshakes on both sides.
module square_root_seq
    import square_root_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     num,
    input  logic                 rnd,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH/2-1:0]   sqr,
    output logic [WIDTH/2:0]     rem,
    output logic                 exact,
    output logic                 sqr_flag,
    input  logic                 out_ready
);
    localparam int RW = WIDTH / 2;
    localparam int CW = clog2(RW);
    state_t          state, state_nxt;
    logic [WIDTH-1:0] num_sh;
    logic            rnd_q;
    logic [CW-1:0]   cnt;
    logic [RW+1:0]   rem_acc, rem_nxt;
    logic [RW-1:0]   root_acc, root_nxt;
    logic            round_up;
    sqrt_step #(.RW(RW)) u_step (
        .rem_acc  (rem_acc),
        .root_acc (root_acc),
        .pair     (num_sh[WIDTH-1 -: 2]),
        .rem_nxt  (rem_nxt),
        .root_nxt (root_nxt)
    );
    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (state == S_IDLE && in_valid)        state_nxt = S_BUSY;
        else if (state == S_BUSY && cnt == '0)  state_nxt = S_DONE;
        else if (state == S_DONE && out_ready)  state_nxt = S_IDLE;
    end
    assign in_ready = RST && state == S_IDLE;
    assign sqr_flag = state == S_DONE;
    // (r+0.5)^2 = r^2 + r + 0.25, so round up exactly when rem > r; saturate at all ones
    assign round_up = rnd_q && ({1'b0, rem_nxt} > {3'b000, root_nxt}) && !(&root_nxt);
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            num_sh   <= '0;
            rnd_q    <= 1'b0;
            cnt      <= '0;
            rem_acc  <= '0;
            root_acc <= '0;
            sqr      <= '0;
            rem      <= '0;
            exact    <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            num_sh   <= num;
            rnd_q    <= rnd;
            cnt      <= CW'(RW - 1);
            rem_acc  <= '0;
            root_acc <= '0;
        end else if (state == S_BUSY) begin
            num_sh   <= num_sh << 2;
            cnt      <= cnt - 1'b1;
            rem_acc  <= rem_nxt;
            root_acc <= root_nxt;
            if (cnt == '0) begin
                sqr   <= root_nxt + RW'(round_up);
                rem   <= rem_nxt[RW:0];
                exact <= rem_nxt == '0;
            end
        end
    end
endmodule

// File: tb/tb_square_root_seq.sv
// tb_square_root_seq: directed and random checks of square_root_seq against an arithmetic reference.
module tb_square_root_seq;
    localparam int W  = 16;
    localparam int RW = W / 2;
    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [W-1:0]  num = '0;
    logic          rnd = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, exact, sqr_flag;
    logic [RW-1:0] sqr;
    logic [RW:0]   rem;
    int vectors = 0;
    int errors  = 0;

    square_root_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .num(num), .rnd(rnd), .in_valid(in_valid),
        .in_ready(in_ready), .sqr(sqr), .rem(rem), .exact(exact),
        .sqr_flag(sqr_flag), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint isqrt(input longint n);
        longint r = 0;
        for (int b = RW - 1; b >= 0; b--)
            if ((r + (longint'(1) << b)) * (r + (longint'(1) << b)) <= n) r += longint'(1) << b;
        return r;
    endfunction

    task automatic run(input logic [W-1:0] n, input logic m, input int hold, input string tag);
        longint f, rm, e;
        int lat;
        f  = isqrt(longint'(n));
        rm = longint'(n) - f * f;
        e  = (m && ((f + 1) * (f + 1) - longint'(n)) < rm && f < (longint'(1) << RW) - 1) ? f + 1 : f;
        @(negedge CLK);
        num = n; rnd = m; in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge CLK);
        in_valid = 1'b0; num = W'($urandom); rnd = ~m;
        lat = 0;
        while (!sqr_flag && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(RW));
        check({tag, "_sqr"}, 64'(sqr), 64'(e));
        check({tag, "_rem"}, 64'(rem), 64'(rm));
        check({tag, "_exact"}, 64'(exact), 64'(rm == 0));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            in_valid = (i == 3);
            num = '0;
            check({tag, "_hold_flag"}, 64'(sqr_flag), 64'd1);
            check({tag, "_hold_sqr"}, 64'(sqr), 64'(e));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check({tag, "_flag_drop"}, 64'(sqr_flag), 64'd0);
        check({tag, "_idle_hold"}, 64'(sqr), 64'(e));
    endtask

    initial begin
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_flag", 64'(sqr_flag), 64'd0);
        check("rst_outputs", 64'({sqr, rem, exact}), 64'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1 check("idle_in_ready", 64'(in_ready), 64'd1);

        run(16'd4,     1'b0, 0, "n4");
        run(16'd33,    1'b0, 0, "n33_floor");
        run(16'd33,    1'b1, 0, "n33_round");
        run(16'd6536,  1'b0, 0, "n6536_floor");
        run(16'd6536,  1'b1, 0, "n6536_round");
        run(16'd121,   1'b1, 0, "n121_round");
        run(16'd65535, 1'b0, 0, "max_floor");
        run(16'd65535, 1'b1, 0, "max_round_sat");
        run(16'd0,     1'b0, 0, "zero");
        run(16'd65280, 1'b1, 0, "n65280_round");
        run(16'd1000,  1'b1, 10, "backpressure");
        run(16'd2,     1'b1, 0, "after_bp");

        @(negedge CLK);
        num = 16'd65535; rnd = 1'b0; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abort_flag", 64'(sqr_flag), 64'd0);
        check("abort_outputs", 64'({sqr, rem, exact}), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (RW + 2) @(negedge CLK);
        check("abort_no_result", 64'(sqr_flag), 64'd0);
        run(16'd25, 1'b0, 0, "after_abort");

        for (int i = 0; i < 300; i++)
            run(W'($urandom), 1'($urandom), 0, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
